sobel_engine: RTL and testbench

- Sits directly downstream of the 640x480 frame RAM (mem_sobel) and is the read-side master of that RAM.
- Sequences read strobes to pull 3x3 windows, one 72-bit word per request.
- Computes the Sobel gradient magnitude for each window in a 2-stage pipeline.
- Streams one 8-bit edge pixel per window to the output writer, under a valid/ready handshake, until the frame is exhausted.

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/sobel_engine_kernel.sv | 54 +++++
 rtl/sobel_engine.sv | 199 +++++++++++++++++++
 tb/tb_sobel_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, window byte map, request FSM states and sizing helper
// for the Sobel edge engine.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam int REQ_CNT_W = 19;

  // LSB position of each pixel inside the 72-bit window word (pRC: R=row, C=column)
  localparam int P00_LSB = 64;
  localparam int P10_LSB = 56;
  localparam int P20_LSB = 48;
  localparam int P01_LSB = 40;
  localparam int P11_LSB = 32;
  localparam int P21_LSB = 24;
  localparam int P02_LSB = 16;
  localparam int P12_LSB = 8;
  localparam int P22_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    REL,
    DRAIN
  } state_e;

  // Number of full 3x3 windows in a rows x cols frame
  function automatic int num_windows(input int rows, input int cols);
    return (rows - 2) * (cols - 2);
  endfunction

endpackage

// File: rtl/sobel_engine_kernel.sv
// Combinational Sobel datapath: window -> signed Gx/Gy, and registered
// Gx/Gy -> edge pixel (saturated magnitude or thresholded).
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int BINARIZE = 0,
  parameter int THRESH   = 100
) (
  input  logic [WIN_W-1:0]  win,
  output logic signed [10:0] gx,
  output logic signed [10:0] gy,
  input  logic signed [10:0] gx_r,
  input  logic signed [10:0] gy_r,
  output logic [PIX_W-1:0]  pix
);

  logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
  logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [9:0] abs_x, abs_y;
  logic [10:0] mag;

  assign p00 = win[P00_LSB +: 8];
  assign p01 = win[P01_LSB +: 8];
  assign p02 = win[P02_LSB +: 8];
  assign p10 = win[P10_LSB +: 8];
  assign p12 = win[P12_LSB +: 8];
  assign p20 = win[P20_LSB +: 8];
  assign p21 = win[P21_LSB +: 8];
  assign p22 = win[P22_LSB +: 8];

  // Weighted column/row sums fit 10 bits (max 1020); differences fit 11-bit signed
  always_comb begin
    gx_pos = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
    gx_neg = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
    gy_pos = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
    gy_neg = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};
    gx     = {1'b0, gx_pos} - {1'b0, gx_neg};
    gy     = {1'b0, gy_pos} - {1'b0, gy_neg};
  end

  // |Gx| + |Gy| then either clamp to 8 bits or compare against the threshold
  always_comb begin
    abs_x = gx_r[10] ? 10'(-gx_r) : gx_r[9:0];
    abs_y = gy_r[10] ? 10'(-gy_r) : gy_r[9:0];
    mag   = {1'b0, abs_x} + {1'b0, abs_y};
    pix   = '0;
    if (BINARIZE != 0) begin
      pix = (mag >= 11'(THRESH)) ? 8'hFF : 8'h00;
    end else begin
      pix = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end
  end

endmodule

// File: rtl/sobel_engine.sv
// Sobel edge engine: read-side master of the frame RAM, fetches one 3x3
// window per strobe, runs it through a 2-stage gradient pipeline and streams
// edge pixels out under valid/ready.
module sobel_engine
  import sobel_pkg::*;
#(
  parameter int ROWS       = 480,
  parameter int COLS       = 640,
  parameter int STROBE_CYC = 2,
  parameter int BINARIZE   = 0,
  parameter int THRESH     = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_in,
  output logic             mem_strobe_n,
  output logic             mem_rw,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             busy,
  output logic             done
);

  localparam logic [REQ_CNT_W-1:0] NUM_WIN = REQ_CNT_W'(num_windows(ROWS, COLS));
  localparam int SCNT_W = $clog2(STROBE_CYC + 1);

  state_e                 state_q, state_d;
  logic [SCNT_W-1:0]      strb_cnt_q, strb_cnt_d;
  logic [REQ_CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic                   strobe_n_q, strobe_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [WIN_W-1:0]       s0_win_q, s0_win_d;
  logic                   s0_valid_q, s0_valid_d;
  logic                   s0_last_q, s0_last_d;
  logic signed [10:0]     s1_gx_q, s1_gx_d;
  logic signed [10:0]     s1_gy_q, s1_gy_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   pix_last_q, pix_last_d;

  logic                   pipe_en;
  logic                   load;
  logic [REQ_CNT_W-1:0]   req_inc;
  logic                   final_xfer;
  logic signed [10:0]     k_gx, k_gy;
  logic [PIX_W-1:0]       k_pix;

  assign pipe_en    = !pix_valid_q || pix_ready;
  assign load       = (state_q == CAPT) && pipe_en;
  assign req_inc    = (req_cnt_q == '1) ? req_cnt_q : req_cnt_q + 1'b1;
  assign final_xfer = pix_valid_q && pix_ready && pix_last_q;

  sobel_kernel #(
    .BINARIZE (BINARIZE),
    .THRESH   (THRESH)
  ) u_kernel (
    .win  (s0_win_q),
    .gx   (k_gx),
    .gy   (k_gy),
    .gx_r (s1_gx_q),
    .gy_r (s1_gy_q),
    .pix  (k_pix)
  );

  // Request sequencing: strobe low through REQ and CAPT, one high clock in REL to re-arm the RAM
  always_comb begin
    state_d    = state_q;
    strb_cnt_d = strb_cnt_q;
    req_cnt_d  = req_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          busy_d     = 1'b1;
          req_cnt_d  = '0;
          strb_cnt_d = '0;
        end
      end
      REQ: begin
        if (strb_cnt_q == SCNT_W'(STROBE_CYC - 1)) begin
          state_d = CAPT;
        end else begin
          strb_cnt_d = strb_cnt_q + 1'b1;
        end
      end
      CAPT: begin
        if (pipe_en) begin
          req_cnt_d = req_inc;
          state_d   = REL;
        end
      end
      REL: begin
        strb_cnt_d = '0;
        state_d    = (req_cnt_q < NUM_WIN) ? REQ : DRAIN;
      end
      DRAIN: begin
        if (final_xfer) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    strobe_n_d = !((state_d == REQ) || (state_d == CAPT));
  end

  // Request FSM registers; strobe is registered from the next state so it lines up with state_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      strb_cnt_q <= '0;
      req_cnt_q  <= '0;
      strobe_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      strb_cnt_q <= strb_cnt_d;
      req_cnt_q  <= req_cnt_d;
      strobe_n_q <= strobe_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Pipeline advance: every stage moves together only when the output slot is free or being taken
  always_comb begin
    s0_win_d    = s0_win_q;
    s0_valid_d  = s0_valid_q;
    s0_last_d   = s0_last_q;
    s1_gx_d     = s1_gx_q;
    s1_gy_d     = s1_gy_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    if (pipe_en) begin
      s0_valid_d  = load;
      s0_last_d   = load && (req_inc == NUM_WIN);
      if (load) begin
        s0_win_d = win_in;
      end
      s1_gx_d     = k_gx;
      s1_gy_d     = k_gy;
      s1_valid_d  = s0_valid_q;
      s1_last_d   = s0_last_q;
      pix_d       = k_pix;
      pix_valid_d = s1_valid_q;
      pix_last_d  = s1_last_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_win_q    <= '0;
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      s0_win_q    <= s0_win_d;
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      s1_gx_q     <= s1_gx_d;
      s1_gy_q     <= s1_gy_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign mem_strobe_n = strobe_n_q;
  assign mem_rw       = 1'b1;
  assign pix_out      = pix_q;
  assign pix_valid    = pix_valid_q;
  assign pix_last     = pix_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sobel_engine.sv
// Scoreboard bench for sobel_engine on a 4x5 frame (6 windows). Two instances
// share stimulus: one saturating, one binarizing at THRESH=100.
module tb_sobel_engine;
  import sobel_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int NW   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pix_ready = 1'b1;
  logic [71:0] win_in = '0;

  logic       strobe_n_a, rw_a, valid_a, last_a, busy_a, done_a;
  logic [7:0] pix_a;
  logic       strobe_n_b, rw_b, valid_b, last_b, busy_b, done_b;
  logic [7:0] pix_b;

  typedef struct {
    logic [7:0] sat;
    logic [7:0] bin;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         total_pix = 0;
  int         done_cnt = 0;

  logic [71:0] ram [NW];
  int         ram_idx = 0;
  logic       ram_rewind = 1'b0;
  logic       strobe_prev = 1'b1;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_pix = '0;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  sobel_engine #(
    .ROWS(ROWS), .COLS(COLS), .STROBE_CYC(2), .BINARIZE(0), .THRESH(100)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start), .win_in(win_in),
    .mem_strobe_n(strobe_n_a), .mem_rw(rw_a), .pix_out(pix_a),
    .pix_valid(valid_a), .pix_ready(pix_ready), .pix_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  sobel_engine #(
    .ROWS(ROWS), .COLS(COLS), .STROBE_CYC(2), .BINARIZE(1), .THRESH(100)
  ) dut_bin (
    .clk(clk), .reset(reset), .start(start), .win_in(win_in),
    .mem_strobe_n(strobe_n_b), .mem_rw(rw_b), .pix_out(pix_b),
    .pix_valid(valid_b), .pix_ready(pix_ready), .pix_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [71:0] mkwin(input logic [7:0] p00, p01, p02,
                                        input logic [7:0] p10, p11, p12,
                                        input logic [7:0] p20, p21, p22);
    return {p00, p10, p20, p01, p11, p21, p02, p12, p22};
  endfunction

  task automatic loadWin(input int i, input logic [71:0] w, input logic [7:0] es, input logic [7:0] eb);
    ram[i] = w;
    exp_q.push_back('{sat: es, bin: eb, last: (i == NW - 1)});
  endtask

  // RAM model: advances to the next window each time the strobe is released
  always @(negedge clk) begin
    if (ram_rewind) ram_idx = 0;
    else if (strobe_prev == 1'b0 && strobe_n_a == 1'b1) ram_idx = ram_idx + 1;
    strobe_prev = strobe_n_a;
    win_in = (ram_idx < NW) ? ram[ram_idx] : 72'd0;
  end

  // Monitor: pops the scoreboard on every transfer and checks output stability under stall
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", int'(valid_a), 1);
        checkOutput("hold_pix", int'(pix_a), int'(prev_pix));
        checkOutput("hold_last", int'(last_a), int'(prev_last));
      end
      if (valid_a && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_pixel: got %0d, expected no pixel", pix_a);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("pix_sat", int'(pix_a), int'(e.sat));
          checkOutput("valid_bin", int'(valid_b), 1);
          checkOutput("pix_bin", int'(pix_b), int'(e.bin));
          checkOutput("pix_last", int'(last_a), int'(e.last));
        end
        total_pix++;
      end
      if (done_a) done_cnt++;
      prev_stall = valid_a && !pix_ready;
      prev_pix   = pix_a;
      prev_last  = last_a;
    end
  end

  task automatic applyStimulus(input int sel);
    @(posedge clk); #1;
    ram_rewind = 1'b1;
    if (sel == 0) begin
      loadWin(0, mkwin(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'd0,   8'd0);
      loadWin(1, mkwin(10, 15, 20, 10, 15, 20, 10, 15, 20),                               8'd40,  8'd0);
      loadWin(2, mkwin(0, 128, 255, 0, 128, 255, 0, 128, 255),                            8'd255, 8'd255);
      loadWin(3, mkwin(0, 0, 0, 15, 15, 15, 30, 30, 30),                                  8'd120, 8'd255);
      loadWin(4, mkwin(0, 0, 0, 15, 15, 15, 20, 20, 20),                                  8'd80,  8'd0);
      loadWin(5, mkwin(0, 0, 25, 0, 0, 25, 0, 0, 25),                                     8'd100, 8'd255);
    end else begin
      loadWin(0, mkwin(25, 0, 0, 25, 0, 0, 25, 0, 0),                                     8'd100, 8'd255);
      loadWin(1, mkwin(0, 0, 0, 0, 0, 0, 0, 0, 99),                                       8'd198, 8'd255);
      loadWin(2, mkwin(60, 0, 0, 0, 0, 0, 0, 0, 0),                                       8'd120, 8'd255);
      loadWin(3, mkwin(0, 0, 0, 0, 200, 0, 0, 0, 0),                                      8'd0,   8'd0);
      loadWin(4, mkwin(0, 0, 0, 0, 0, 49, 0, 0, 0),                                       8'd98,  8'd0);
      loadWin(5, mkwin(0, 0, 0, 128, 0, 0, 0, 0, 0),                                      8'd255, 8'd255);
    end
    @(posedge clk); #1;
    ram_rewind = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_strobe_n"}, int'(strobe_n_a), 1);
    checkOutput({tag, "_mem_rw"},   int'(rw_a), 1);
    checkOutput({tag, "_pix_out"},  int'(pix_a), 0);
    checkOutput({tag, "_pix_valid"}, int'(valid_a), 0);
    checkOutput({tag, "_pix_last"}, int'(last_a), 0);
    checkOutput({tag, "_busy"},     int'(busy_a), 0);
    checkOutput({tag, "_done"},     int'(done_a), 0);
    checkOutput({tag, "_valid_bin"}, int'(valid_b), 0);
  endtask

  task automatic waitDone(input int base);
    int guard = 0;
    @(negedge clk);
    while (!done_a && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    if (!done_a) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL done_timeout: got no done pulse, expected one within 400 cycles");
    end else begin
      checkOutput("busy_after_done", int'(busy_a), 0);
      checkOutput("queue_empty", exp_q.size(), 0);
      checkOutput("frame_pixels", total_pix - base, NW);
      @(negedge clk);
      checkOutput("done_one_cycle", int'(done_a), 0);
      checkOutput("valid_after_done", int'(valid_a), 0);
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int lo;
    int hi;
    int guard;
    logic saw_valid;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b1;

    // Frame 0: kernel vectors, strobe pattern, latency, ignored start
    $display("[TB] frame 0: strobe timing and kernel vectors");
    base = total_pix;
    applyStimulus(0);
    lo = 0;
    hi = 0;
    @(negedge clk);
    while (strobe_n_a == 1'b0 && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    checkOutput("latency_edge0_valid", int'(valid_a), 0);
    while (strobe_n_a == 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("strobe_low_cycles", lo, 3);
    checkOutput("strobe_high_cycles", hi, 1);
    checkOutput("latency_edge1_valid", int'(valid_a), 0);
    @(negedge clk);
    checkOutput("latency_edge2_valid", int'(valid_a), 1);
    checkOutput("busy_in_pass", int'(busy_a), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(base);

    // Frame 1: backpressure for 10 clocks mid-frame
    $display("[TB] frame 1: backpressure");
    base = total_pix;
    applyStimulus(1);
    guard = 0;
    while (total_pix < base + 2 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    pix_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_strobe_parked", int'(strobe_n_a), 0);
    checkOutput("stall_valid_held", int'(valid_a), 1);
    checkOutput("stall_busy", int'(busy_a), 1);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    waitDone(base);

    // Frame 2: reset during REQ with one pixel in flight
    $display("[TB] frame 2: abort by reset");
    applyStimulus(0);
    guard = 0;
    @(negedge clk);
    while (strobe_n_a == 1'b0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("abort_in_req_strobe", int'(strobe_n_a), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkResetValues("abort");
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid_a || valid_b) saw_valid = 1'b1;
    end
    checkOutput("no_valid_after_abort", int'(saw_valid), 0);
    checkOutput("idle_after_abort_busy", int'(busy_a), 0);

    // Frame 3: clean pass after the abort
    $display("[TB] frame 3: recovery pass");
    base = total_pix;
    applyStimulus(1);
    waitDone(base);

    checkOutput("done_pulse_count", done_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
